// File: rtl/rst_seq.sv
// ---------------------------------------------------------------------------
// rst_seq -- reset release sequencer
//
// Holds NUM_CH active-low reset outputs low while the system reset is
// asserted. After reset is removed it waits NUM_STAGES cycles, then releases
// the channels one at a time in ascending index order, GAP_CYCLES apart.
// Once every channel is released the block sits in RUN with RST_DONE high.
//
// Optional feature macro: RST_SEQ_SW_RST_EN
//   When defined, each channel gets a software reset pulse. In RUN, a sampled
//   SW_RST_REQ[i]=1 drives SYNC_RST[i] low for PULSE_CYCLES cycles, and a
//   request during an active pulse restarts its count.
//   When undefined, SW_RST_REQ is ignored and SYNC_RST stays all ones in RUN.
//
// Ports:
//   CLK         in   1       clock, rising edge
//   RST         in   1       synchronous active-low reset
//   SW_RST_REQ  in   NUM_CH  per-channel software reset request (level)
//   SYNC_RST    out  NUM_CH  per-channel active-low reset, registered
//   RST_DONE    out  1       high once the sequence has finished (RUN)
//   state_dbg   out  2       current FSM state (HOLD=0, STRETCH=1,
//                            RELEASE=2, RUN=3), for observation only
//
// There is no valid/ready handshake: SW_RST_REQ is a plain level sampled on
// every rising edge and has no acknowledge.
// ---------------------------------------------------------------------------
module rst_seq #(
  parameter int NUM_CH       = 3,
  parameter int NUM_STAGES   = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int PULSE_CYCLES = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] SW_RST_REQ,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE,
  output logic [1:0]        state_dbg
);

  // Counter widths sized to hold their terminal value; always at least 1 bit.
  localparam int SW = $clog2(NUM_STAGES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t            state;
  logic [SW-1:0]     stage_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [IW-1:0]     ch_idx;     // next channel to release
  logic [NUM_CH-1:0] sync_q;
  logic              done_q;

`ifdef RST_SEQ_SW_RST_EN
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  // Remaining low cycles of each channel's software pulse; zero means idle.
  logic [PW-1:0] pulse_cnt [NUM_CH];
`else
  // Requests have no effect in this build; fold them so they count as used.
  logic unused_sw_req;
  assign unused_sw_req = ^SW_RST_REQ;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= HOLD;
      stage_cnt <= '0;
      gap_cnt   <= '0;
      ch_idx    <= '0;
      sync_q    <= '0;
      done_q    <= 1'b0;
`ifdef RST_SEQ_SW_RST_EN
      for (int i = 0; i < NUM_CH; i++) pulse_cnt[i] <= '0;
`endif
    end else begin
      case (state)
        // First edge with reset removed (e0): start the stretch count.
        HOLD: begin
          state     <= STRETCH;
          stage_cnt <= '0;
          gap_cnt   <= '0;
          ch_idx    <= '0;
          sync_q    <= '0;
          done_q    <= 1'b0;
        end

        // Channel 0 goes high on edge e0+NUM_STAGES, i.e. when the count
        // started at e0 reaches NUM_STAGES-1.
        STRETCH: begin
          if (stage_cnt == SW'(NUM_STAGES - 1)) begin
            stage_cnt <= '0;
            sync_q[0] <= 1'b1;
            gap_cnt   <= '0;
            if (NUM_CH == 1) begin
              state  <= RUN;
              done_q <= 1'b1;
            end else begin
              state  <= RELEASE;
              ch_idx <= IW'(1);
            end
          end else begin
            stage_cnt <= stage_cnt + 1'b1;
          end
        end

        // One release every GAP_CYCLES edges; the last one enters RUN.
        RELEASE: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
              if (ch_idx == IW'(i)) sync_q[i] <= 1'b1;
            end
            if (ch_idx == IW'(NUM_CH - 1)) begin
              state  <= RUN;
              done_q <= 1'b1;
            end else begin
              ch_idx <= ch_idx + 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        RUN: begin
          done_q <= 1'b1;
`ifdef RST_SEQ_SW_RST_EN
          // A request always (re)loads the full pulse length, which both
          // starts a new pulse and extends an active one.
          for (int i = 0; i < NUM_CH; i++) begin
            if (SW_RST_REQ[i]) begin
              pulse_cnt[i] <= PW'(PULSE_CYCLES);
              sync_q[i]    <= 1'b0;
            end else if (pulse_cnt[i] != '0) begin
              pulse_cnt[i] <= pulse_cnt[i] - 1'b1;
              if (pulse_cnt[i] == PW'(1)) sync_q[i] <= 1'b1;
            end
          end
`else
          sync_q <= '1;
`endif
        end

        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

  assign SYNC_RST  = sync_q;
  assign RST_DONE  = done_q;
  assign state_dbg = state;

endmodule
